// File: rtl/syn_fifo_pkg.sv
// Shared constants and helpers for the programmable synchronous FIFO family.
package syn_fifo_pkg;

  typedef enum logic {
    FIFO_MODE_STD  = 1'b0,
    FIFO_MODE_FWFT = 1'b1
  } fifo_mode_e;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_dpram.sv
// Simple dual-port RAM: synchronous write, registered read gated by rd_en.
module fifo_dpram
  import syn_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [ptr_w(DEPTH)-1:0]   wr_addr,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic                      rd_en,
  input  logic [ptr_w(DEPTH)-1:0]   rd_addr,
  output logic [WIDTH-1:0]          rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_q, rd_data_d;

  // Array is left uninitialised on reset; only the output register clears.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem[rd_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/syn_fifo_prog.sv
// Single-clock FIFO with selectable standard/FWFT read, programmable
// almost-full/almost-empty thresholds and overflow/underflow pulses.
module syn_fifo_prog
  import syn_fifo_pkg::*;
#(
  parameter int FIFO_WIDTH    = 8,
  parameter int FIFO_DEPTH    = 16,
  parameter int FWFT          = 0,
  parameter int AFULL_THRESH  = FIFO_DEPTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        fifoWrEn,
  input  logic [FIFO_WIDTH-1:0]       fifoWrData,
  output logic                        fifoFull,
  output logic                        fifoAlmostFull,
  output logic                        fifoOverflow,
  input  logic                        fifoRdEn,
  output logic [FIFO_WIDTH-1:0]       fifoRdData,
  output logic                        fifoRdValid,
  output logic                        fifoEmpty,
  output logic                        fifoAlmostEmpty,
  output logic                        fifoUnderflow,
  output logic [$clog2(FIFO_DEPTH):0] fifoDataCount
);

  localparam int unsigned PTR_W = ptr_w(FIFO_DEPTH);
  localparam int unsigned CNT_W = cnt_w(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_THRESH);
  localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_THRESH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d, udf_q, udf_d;
  logic             wr_accept, rd_accept, ram_rd_en, can_read;

  assign fifoFull        = (count_q == DEPTH_C);
  assign fifoAlmostFull  = (count_q >= AFULL_C);
  assign fifoAlmostEmpty = (count_q <= AEMPTY_C);
  assign fifoEmpty       = ~can_read;
  assign fifoDataCount   = count_q;
  assign fifoRdValid     = valid_q;
  assign fifoOverflow    = ovf_q;
  assign fifoUnderflow   = udf_q;

  assign wr_accept = fifoWrEn & ~fifoFull;
  assign rd_accept = fifoRdEn & can_read;

  if (FWFT == int'(FIFO_MODE_FWFT)) begin : g_fwft
    // count includes the word parked in the RAM output register, so words
    // still in the array are count - valid; refill whenever the head slot
    // is free or being acknowledged this cycle.
    assign can_read  = valid_q;
    assign ram_rd_en = (count_q > CNT_W'(valid_q)) & (~valid_q | rd_accept);
    assign valid_d   = ram_rd_en | (valid_q & ~rd_accept);
  end else begin : g_std
    assign can_read  = (count_q != '0);
    assign ram_rd_en = rd_accept;
    assign valid_d   = rd_accept;
  end

  always_comb begin
    count_d = count_q;
    if (wr_accept && !rd_accept)      count_d = count_q + CNT_W'(1);
    else if (rd_accept && !wr_accept) count_d = count_q - CNT_W'(1);
    wr_ptr_d = wr_ptr_q + PTR_W'(wr_accept);
    rd_ptr_d = rd_ptr_q + PTR_W'(ram_rd_en);
    ovf_d    = fifoWrEn & fifoFull;
    udf_d    = fifoRdEn & ~can_read;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  fifo_dpram #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_ram (
    .clk     (clk),
    .rst     (reset),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr_q),
    .wr_data (fifoWrData),
    .rd_en   (ram_rd_en),
    .rd_addr (rd_ptr_q),
    .rd_data (fifoRdData)
  );

endmodule

// File: tb/tb_syn_fifo_prog.sv
// Bench for syn_fifo_prog: one standard and one FWFT instance against queue models.
module tb_syn_fifo_prog;

  localparam int D = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic       s_wr = 0, s_rd = 0, f_wr = 0, f_rd = 0;
  logic [7:0] s_wd = '0, f_wd = '0;
  logic [7:0] s_rdata, f_rdata;
  logic       s_full, s_afull, s_ovf, s_rvalid, s_empty, s_aempty, s_udf;
  logic       f_full, f_afull, f_ovf, f_rvalid, f_empty, f_aempty, f_udf;
  logic [4:0] s_cnt, f_cnt;
  logic [11:0] s_stat, f_stat;

  assign s_stat = {s_cnt, s_full, s_afull, s_ovf, s_rvalid, s_empty, s_aempty, s_udf};
  assign f_stat = {f_cnt, f_full, f_afull, f_ovf, f_rvalid, f_empty, f_aempty, f_udf};

  syn_fifo_prog #(.FIFO_WIDTH(8), .FIFO_DEPTH(D), .FWFT(0), .AFULL_THRESH(D-2), .AEMPTY_THRESH(2)) u_std (
    .clk(clk), .reset(reset), .fifoWrEn(s_wr), .fifoWrData(s_wd), .fifoFull(s_full),
    .fifoAlmostFull(s_afull), .fifoOverflow(s_ovf), .fifoRdEn(s_rd), .fifoRdData(s_rdata),
    .fifoRdValid(s_rvalid), .fifoEmpty(s_empty), .fifoAlmostEmpty(s_aempty),
    .fifoUnderflow(s_udf), .fifoDataCount(s_cnt));

  syn_fifo_prog #(.FIFO_WIDTH(8), .FIFO_DEPTH(D), .FWFT(1), .AFULL_THRESH(D-2), .AEMPTY_THRESH(2)) u_fwft (
    .clk(clk), .reset(reset), .fifoWrEn(f_wr), .fifoWrData(f_wd), .fifoFull(f_full),
    .fifoAlmostFull(f_afull), .fifoOverflow(f_ovf), .fifoRdEn(f_rd), .fifoRdData(f_rdata),
    .fifoRdValid(f_rvalid), .fifoEmpty(f_empty), .fifoAlmostEmpty(f_aempty),
    .fifoUnderflow(f_udf), .fifoDataCount(f_cnt));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: plain queues. FWFT entries remember the edge they were
  // written at; a head word is visible once at least one edge has passed.
  typedef struct { logic [7:0] d; int e; } ent_t;
  logic [7:0] sq[$];
  ent_t       fq[$];
  logic [7:0] s_exp_data, f_exp_data;
  bit         s_exp_valid, s_exp_ovf, s_exp_udf;
  bit         f_exp_valid, f_exp_ovf, f_exp_udf;
  int         edge_n = 0;

  function automatic logic [11:0] s_exp_stat();
    return {5'(sq.size()), sq.size() == D, sq.size() >= D-2, s_exp_ovf, s_exp_valid,
            sq.size() == 0, sq.size() <= 2, s_exp_udf};
  endfunction

  function automatic logic [11:0] f_exp_stat();
    return {5'(fq.size()), fq.size() == D, fq.size() >= D-2, f_exp_ovf, f_exp_valid,
            !f_exp_valid, fq.size() <= 2, f_exp_udf};
  endfunction

  task automatic model_reset();
    sq.delete(); fq.delete();
    s_exp_data = '0; f_exp_data = '0;
    {s_exp_valid, s_exp_ovf, s_exp_udf, f_exp_valid, f_exp_ovf, f_exp_udf} = '0;
  endtask

  task automatic step(input bit sw, input logic [7:0] sd, input bit sr,
                      input bit fw, input logic [7:0] fd, input bit fr);
    bit s_full_m, s_empty_m, f_racc, f_wacc;
    @(negedge clk);
    s_wr = sw; s_wd = sd; s_rd = sr;
    f_wr = fw; f_wd = fd; f_rd = fr;
    @(posedge clk);
    edge_n++;
    s_full_m  = (sq.size() == D);
    s_empty_m = (sq.size() == 0);
    s_exp_ovf   = sw && s_full_m;
    s_exp_udf   = sr && s_empty_m;
    s_exp_valid = sr && !s_empty_m;
    if (sr && !s_empty_m) s_exp_data = sq.pop_front();
    if (sw && !s_full_m) sq.push_back(sd);
    f_racc = fr && f_exp_valid;
    f_wacc = fw && (fq.size() < D);
    f_exp_ovf = fw && (fq.size() == D);
    f_exp_udf = fr && !f_exp_valid;
    if (f_racc) void'(fq.pop_front());
    if (f_wacc) fq.push_back('{d: fd, e: edge_n});
    f_exp_valid = (fq.size() > 0) && (fq[0].e < edge_n);
    if (f_exp_valid) f_exp_data = fq[0].d;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    {s_wr, s_rd, f_wr, f_rd} = '0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    {s_wr, s_rd, f_wr, f_rd} = '0;
    #1 reset = 1'b1;
    #20;
    n_tests++;
    if (s_stat !== 12'b00000_0_0_0_0_1_1_0) begin n_fail++; $display("FAIL reset_std_status got %b exp %b", s_stat, 12'b00000_0_0_0_0_1_1_0); end
    n_tests++;
    if (f_stat !== 12'b00000_0_0_0_0_1_1_0) begin n_fail++; $display("FAIL reset_fwft_status got %b exp %b", f_stat, 12'b00000_0_0_0_0_1_1_0); end
    n_tests++;
    if (s_rdata !== 8'h00 || f_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata got %h/%h exp 00/00", s_rdata, f_rdata); end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_fill_drain_std();
    for (int i = 1; i <= D; i++) begin
      step(1, 8'(i), 0, 0, 0, 0);
      n_tests++;
      if (s_stat !== s_exp_stat()) begin n_fail++; $display("FAIL fill_status[%0d] got %b exp %b", i, s_stat, s_exp_stat()); end
      n_tests++;
      if (s_afull !== (i >= 14)) begin n_fail++; $display("FAIL fill_afull[%0d] got %b exp %b", i, s_afull, i >= 14); end
    end
    n_tests++;
    if (s_full !== 1'b1 || s_cnt !== 5'd16) begin n_fail++; $display("FAIL fill_full got full=%b cnt=%0d exp full=1 cnt=16", s_full, s_cnt); end
    for (int i = 1; i <= D; i++) begin
      step(0, 0, 1, 0, 0, 0);
      n_tests++;
      if (s_rdata !== 8'(i) || s_rvalid !== 1'b1) begin n_fail++; $display("FAIL drain_data[%0d] got %h v=%b exp %h v=1", i, s_rdata, s_rvalid, 8'(i)); end
      n_tests++;
      if (s_stat !== s_exp_stat()) begin n_fail++; $display("FAIL drain_status[%0d] got %b exp %b", i, s_stat, s_exp_stat()); end
    end
    step(0, 0, 0, 0, 0, 0);
    n_tests++;
    if (s_empty !== 1'b1 || s_rvalid !== 1'b0 || s_rdata !== 8'h10) begin
      n_fail++; $display("FAIL drain_end got empty=%b v=%b d=%h exp empty=1 v=0 d=10", s_empty, s_rvalid, s_rdata);
    end
  endtask

  task automatic test_overflow_underflow();
    for (int i = 0; i < D; i++) step(1, 8'($urandom), 0, 1, 8'($urandom), 0);
    step(1, 8'hEE, 0, 1, 8'hEE, 0);
    n_tests++;
    if (s_ovf !== 1'b1 || s_cnt !== 5'd16 || f_ovf !== 1'b1 || f_cnt !== 5'd16) begin
      n_fail++; $display("FAIL overflow_pulse got ovf=%b/%b cnt=%0d/%0d exp 1/1 16/16", s_ovf, f_ovf, s_cnt, f_cnt);
    end
    step(0, 0, 0, 0, 0, 0);
    n_tests++;
    if (s_ovf !== 1'b0 || f_ovf !== 1'b0) begin n_fail++; $display("FAIL overflow_single got %b/%b exp 0/0", s_ovf, f_ovf); end
    for (int i = 0; i < D; i++) begin
      step(0, 0, 1, 0, 0, 1);
      n_tests++;
      if (s_rdata !== s_exp_data || (f_exp_valid && f_rdata !== f_exp_data)) begin
        n_fail++; $display("FAIL ovf_drain_data[%0d] got %h/%h exp %h/%h", i, s_rdata, f_rdata, s_exp_data, f_exp_data);
      end
    end
    step(0, 0, 1, 0, 0, 1);
    n_tests++;
    if (s_udf !== 1'b1 || s_cnt !== 5'd0 || f_udf !== 1'b1 || f_cnt !== 5'd0) begin
      n_fail++; $display("FAIL underflow_pulse got udf=%b/%b cnt=%0d/%0d exp 1/1 0/0", s_udf, f_udf, s_cnt, f_cnt);
    end
    step(0, 0, 0, 0, 0, 0);
    n_tests++;
    if (s_udf !== 1'b0 || f_udf !== 1'b0) begin n_fail++; $display("FAIL underflow_single got %b/%b exp 0/0", s_udf, f_udf); end
  endtask

  task automatic test_simul_wrap();
    for (int i = 0; i < 5; i++) step(1, 8'($urandom), 0, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      step(1, 8'($urandom), 1, 0, 0, 0);
      n_tests++;
      if (s_cnt !== 5'd5 || s_rdata !== s_exp_data || s_stat !== s_exp_stat()) begin
        n_fail++; $display("FAIL simul_wrap[%0d] got cnt=%0d d=%h exp cnt=5 d=%h", i, s_cnt, s_rdata, s_exp_data);
      end
    end
  endtask

  task automatic test_fwft_single();
    step(0, 0, 0, 1, 8'hA5, 0);
    n_tests++;
    if (f_cnt !== 5'd1 || f_empty !== 1'b1 || f_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL fwft_latency got cnt=%0d empty=%b v=%b exp cnt=1 empty=1 v=0", f_cnt, f_empty, f_rvalid);
    end
    step(0, 0, 0, 0, 0, 0);
    n_tests++;
    if (f_rvalid !== 1'b1 || f_rdata !== 8'hA5 || f_empty !== 1'b0) begin
      n_fail++; $display("FAIL fwft_head got v=%b d=%h empty=%b exp v=1 d=a5 empty=0", f_rvalid, f_rdata, f_empty);
    end
    step(0, 0, 0, 0, 0, 1);
    n_tests++;
    if (f_empty !== 1'b1 || f_cnt !== 5'd0 || f_stat !== f_exp_stat()) begin
      n_fail++; $display("FAIL fwft_ack got empty=%b cnt=%0d exp empty=1 cnt=0", f_empty, f_cnt);
    end
  endtask

  task automatic test_fwft_stream();
    logic [7:0] words [32];
    for (int i = 0; i < 32; i++) words[i] = 8'($urandom);
    for (int i = 0; i < 34; i++) begin
      step(0, 0, 0, i < 32, (i < 32) ? words[i] : 8'h00, 1);
      n_tests++;
      if (f_stat !== f_exp_stat()) begin n_fail++; $display("FAIL stream_status[%0d] got %b exp %b", i, f_stat, f_exp_stat()); end
      if (i >= 1 && i <= 32) begin
        n_tests++;
        if (f_rvalid !== 1'b1 || f_rdata !== words[i-1]) begin
          n_fail++; $display("FAIL stream_word[%0d] got v=%b d=%h exp v=1 d=%h", i, f_rvalid, f_rdata, words[i-1]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bit hi;
      hi = ((i / 50) % 2) == 0;
      step($urandom_range(3, 0) != 0 ? hi : !hi, 8'($urandom), $urandom_range(3, 0) != 0 ? !hi : hi,
           $urandom_range(3, 0) != 0 ? hi : !hi, 8'($urandom), $urandom_range(3, 0) != 0 ? !hi : hi);
      n_tests++;
      if (s_stat !== s_exp_stat() || s_rdata !== s_exp_data) begin
        n_fail++; $display("FAIL rand_std[%0d] got %b/%h exp %b/%h", i, s_stat, s_rdata, s_exp_stat(), s_exp_data);
      end
      n_tests++;
      if (f_stat !== f_exp_stat() || (f_exp_valid && f_rdata !== f_exp_data)) begin
        n_fail++; $display("FAIL rand_fwft[%0d] got %b/%h exp %b/%h", i, f_stat, f_rdata, f_exp_stat(), f_exp_data);
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 9; i++) step(1, 8'($urandom), 0, 1, 8'($urandom), 0);
    for (int i = 0; i < 2; i++) step(1, 8'($urandom), 1, 1, 8'($urandom), 1);
    n_tests++;
    if (s_cnt !== 5'd9 || f_cnt !== 5'd9) begin n_fail++; $display("FAIL async_pre_count got %0d/%0d exp 9/9", s_cnt, f_cnt); end
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if (s_stat !== 12'b00000_0_0_0_0_1_1_0 || f_stat !== 12'b00000_0_0_0_0_1_1_0 || s_rdata !== 8'h00 || f_rdata !== 8'h00) begin
      n_fail++; $display("FAIL async_reset got %b/%b d=%h/%h exp 000000000110 both d=00", s_stat, f_stat, s_rdata, f_rdata);
    end
    reset = 1'b0;
    model_reset();
    step(1, 8'h3C, 0, 1, 8'h5A, 0);
    n_tests++;
    if (s_cnt !== 5'd1 || f_cnt !== 5'd1) begin n_fail++; $display("FAIL async_first_write got %0d/%0d exp 1/1", s_cnt, f_cnt); end
    step(0, 0, 1, 0, 0, 0);
    n_tests++;
    if (s_rdata !== 8'h3C || s_rvalid !== 1'b1 || f_rdata !== 8'h5A || f_rvalid !== 1'b1) begin
      n_fail++; $display("FAIL async_new_data got %h v=%b / %h v=%b exp 3c v=1 / 5a v=1", s_rdata, s_rvalid, f_rdata, f_rvalid);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fill_drain_std();
    test_overflow_underflow();
    test_simul_wrap();
    do_reset();
    test_fwft_single();
    test_fwft_stream();
    do_reset();
    test_random();
    do_reset();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/syn_fifo_prog.md
# syn_fifo_prog

Parametrised single-clock FIFO, successor to the basic synchronous FIFO. It adds a selectable first-word-fall-through (FWFT) read mode, programmable almost-full/almost-empty thresholds, overflow/underflow pulses and a read-valid strobe. It sits between streaming producers and consumers in the same clock domain and wraps a simple dual-port RAM.

## Interface
- FIFO_WIDTH, 8, data word width (≥1)
- FIFO_DEPTH, 16, word capacity; power of two, ≥4
- FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through
- AFULL_THRESH, FIFO_DEPTH-2, fifoAlmostFull asserts when count ≥ this; range 1..FIFO_DEPTH
- AEMPTY_THRESH, 2, fifoAlmostEmpty asserts when count ≤ this; range 0..FIFO_DEPTH-1
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high
- fifoWrEn  in  1  write request
- fifoWrData  in  FIFO_WIDTH  write word
- fifoFull  out  1  count == FIFO_DEPTH
- fifoAlmostFull  out  1  count ≥ AFULL_THRESH
- fifoOverflow  out  1  one-cycle pulse, rejected write
- fifoRdEn  in  1  read request (standard) / acknowledge of head word (FWFT)
- fifoRdData  out  FIFO_WIDTH  read word
- fifoRdValid  out  1  fifoRdData valid
- fifoEmpty  out  1  no word readable
- fifoAlmostEmpty  out  1  count ≤ AEMPTY_THRESH
- fifoUnderflow  out  1  one-cycle pulse, rejected read
- fifoDataCount  out  $clog2(FIFO_DEPTH)+1  words stored

## Operation
- Reset values: count, pointers, fifoRdData, fifoRdValid, fifoFull, fifoAlmostFull, fifoOverflow, fifoUnderflow = 0; fifoEmpty = 1; fifoAlmostEmpty = 1.
- Write accepted iff fifoWrEn & !fifoFull. Data is written into RAM[wrPtr] at the same edge. No input pipeline stage.
- Standard mode: the read is accepted iff fifoRdEn & !fifoEmpty, with fifoEmpty = (count == 0).
- FWFT mode: fifoEmpty = !fifoRdValid. The head word is held on fifoRdData with fifoRdValid = 1. A read is accepted iff fifoRdEn & fifoRdValid.
- Count: +1 on write only, −1 on read only, unchanged on simultaneous accepted write and read.
- Full blocks writes even when a read is accepted in the same cycle. Empty blocks reads even when a write is accepted in the same cycle.
- Pointers are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH with no special case.
- fifoOverflow is registered: high for exactly the cycle after fifoWrEn is sampled while full. fifoUnderflow works the same way for a rejected read. Rejected requests change no state.
- Flags are decoded combinationally from the registered count and valid state. They are glitch-free relative to clk.

## Timing
- Standard mode: a read accepted at edge N produces fifoRdData = RAM[rdPtr] and fifoRdValid = 1 after edge N. Both hold for one cycle. fifoRdValid drops after edge N+1 unless another read is accepted; fifoRdData holds its last value.
- FWFT mode: a write at edge N into an empty FIFO gives fifoRdValid = 1 after edge N+1. Between N and N+1, fifoDataCount = 1 while fifoEmpty = 1.
- FWFT back-to-back: acknowledging the head at edge N presents the next word after edge N without a bubble, provided count ≥ 2 before N.
- Write to flags: count and all flags update at the same edge as the accepted write or read.
- Reset asserted mid-transfer clears everything immediately. RAM contents are not cleared and are don't-care. The first write after reset deassertion is accepted on the first edge.

## Structure
- Shared package syn_fifo_pkg holds:
  - the pointer-width function/constant (PTR_W = $clog2(FIFO_DEPTH)) and count width (PTR_W+1);
  - the mode encodings FIFO_MODE_STD = 0 and FIFO_MODE_FWFT = 1.
- Sub-module fifo_dpram is a simple dual-port RAM: synchronous write, and a synchronous read with read enable. The read enable lets the FWFT prefetch hold the head word.
- FWFT prefetch/output-valid logic lives in a generate branch in syn_fifo_prog.

## Test plan
- DEPTH=16, standard: write 0x01..0x10 -> fifoFull=1 and count=16 after the 16th edge, fifoAlmostFull from count 14. Then 16 reads -> data 0x01..0x10 each one cycle after its rdEn, fifoEmpty=1 at the end.
- Full with fifoWrEn=1 -> fifoOverflow single-cycle pulse, count stays 16. Empty with fifoRdEn=1 -> fifoUnderflow pulse, count stays 0.
- Simultaneous wr/rd at count 5 for 40 cycles -> count stays 5, pointers wrap twice, data order preserved.
- FWFT=1: single write 0xA5 at edge N -> fifoRdValid=1 and fifoRdData=0xA5 after N+1. rdEn acknowledge -> fifoEmpty=1 next cycle.
- FWFT=1: stream 32 words with rdEn held high and writes every cycle -> no bubbles after the first word, sequence intact.
- Assert reset asynchronously mid-burst at count 9 -> all outputs take reset values before the next edge, and the next write/read pair returns the new data.
